// File: rtl/cm811_init_pkg.sv
// rtl/cm811_init_pkg.sv - shared state encoding and defaults for the CM811 init RAM-check manager
package cm811_init_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_LAUNCH = LAUNCH,
    ST_WAIT   = WAIT,
    ST_REPORT = REPORT
  } state_e;

  localparam int          CH_NUM_MAX      = 32;
  localparam logic [23:0] TIMEOUT_CYC_DEF = 24'd10_000_000;

endpackage

// File: rtl/cm811_sticky_vec.sv
// rtl/cm811_sticky_vec.sv - masked sticky-OR capture vector with synchronous clear and capture enable
module cm811_sticky_vec #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cap_en,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] in_vec,
  output logic [WIDTH-1:0] vec_q,
  output logic [WIDTH-1:0] vec_d
);

  logic [WIDTH-1:0] vec_r;

  // vec_d is exported so the owner can make exit decisions on this cycle's captures
  always_comb begin
    vec_d = vec_r;
    if (clr) begin
      vec_d = '0;
    end else if (cap_en) begin
      vec_d = vec_r | (in_vec & mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_r <= '0;
    end else begin
      vec_r <= vec_d;
    end
  end

  assign vec_q = vec_r;

endmodule

// File: rtl/cm811_init_check_mgr.sv
// rtl/cm811_init_check_mgr.sv - launches per-RAM init checkers and aggregates results; CM811_CHECK_RUN_ALL_EN selects run-to-completion on error
module cm811_init_check_mgr
  import cm811_init_pkg::*;
#(
  parameter int                    CH_NUM      = 16,
  parameter int                    TO_WIDTH    = 24,
  parameter logic [TO_WIDTH-1:0]   TIMEOUT_CYC = TO_WIDTH'(TIMEOUT_CYC_DEF)
) (
  input  logic              sys_clk,
  input  logic              glbl_rst,
  input  logic              check_ram_en,
  input  logic [CH_NUM-1:0] ch_mask,
  output logic              check_ram_busy,
  output logic              check_ram_done,
  output logic              check_ram_error,
  output logic              check_ram_timeout,
  output logic [CH_NUM-1:0] init_check_en,
  input  logic [CH_NUM-1:0] init_check_done,
  input  logic [CH_NUM-1:0] init_check_error,
  output logic [CH_NUM-1:0] ch_done_status,
  output logic [CH_NUM-1:0] ch_err_status
);

  state_e              state_q, state_d;
  logic [CH_NUM-1:0]   mask_q, mask_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic [CH_NUM-1:0]   en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                to_q, to_d;

  logic                clr, cap_en;
  logic [CH_NUM-1:0]   done_vec_q, done_vec_d;
  logic [CH_NUM-1:0]   err_vec_q, err_vec_d;
  logic                err_hit, done_all, to_hit, abort;

  assign cap_en = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);

  cm811_sticky_vec #(.WIDTH(CH_NUM)) u_done_vec (
    .clk    (sys_clk),
    .rst    (glbl_rst),
    .clr    (clr),
    .cap_en (cap_en),
    .mask   (mask_q),
    .in_vec (init_check_done),
    .vec_q  (done_vec_q),
    .vec_d  (done_vec_d)
  );

  cm811_sticky_vec #(.WIDTH(CH_NUM)) u_err_vec (
    .clk    (sys_clk),
    .rst    (glbl_rst),
    .clr    (clr),
    .cap_en (cap_en),
    .mask   (mask_q),
    .in_vec (init_check_error),
    .vec_q  (err_vec_q),
    .vec_d  (err_vec_d)
  );

  assign err_hit  = |err_vec_d;
  assign done_all = ((done_vec_d & mask_q) == mask_q);
  assign to_hit   = (TIMEOUT_CYC != '0) && (cnt_q == TIMEOUT_CYC - 1'b1);

`ifdef CM811_CHECK_RUN_ALL_EN
  assign abort = 1'b0;
`else
  assign abort = err_hit;
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    en_d    = '0;
    to_d    = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (check_ram_en) begin
          mask_d  = ch_mask;
          clr     = 1'b1;
          state_d = (ch_mask == '0) ? ST_REPORT : ST_LAUNCH;
          en_d    = ch_mask;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (abort || done_all) begin
          state_d = ST_REPORT;
        end else if (to_hit) begin
          state_d = ST_REPORT;
          to_d    = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Report outputs are registered, so they are decided on the cycle that enters REPORT
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_REPORT);
    err_d  = (state_d == ST_REPORT) && err_hit;
  end

  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign check_ram_busy    = busy_q;
  assign check_ram_done    = done_q;
  assign check_ram_error   = err_q;
  assign check_ram_timeout = to_q;
  assign init_check_en     = en_q;
  assign ch_done_status    = done_vec_q;
  assign ch_err_status     = err_vec_q;

endmodule

// File: tb/tb_cm811_init_check_mgr.sv
// tb/tb_cm811_init_check_mgr.sv - scoreboard bench for cm811_init_check_mgr with directed and random runs
module tb_cm811_init_check_mgr;

  localparam int CH = 16;
  localparam int T  = 100;

  logic          sys_clk = 1'b0;
  logic          glbl_rst = 1'b1;
  logic          check_ram_en = 1'b0;
  logic [CH-1:0] ch_mask = '0;
  logic [CH-1:0] init_check_done = '0;
  logic [CH-1:0] init_check_error = '0;
  logic          check_ram_busy, check_ram_done, check_ram_error, check_ram_timeout;
  logic [CH-1:0] init_check_en, ch_done_status, ch_err_status;

  cm811_init_check_mgr #(.CH_NUM(CH), .TO_WIDTH(24), .TIMEOUT_CYC(24'd100)) dut (
    .sys_clk           (sys_clk),
    .glbl_rst          (glbl_rst),
    .check_ram_en      (check_ram_en),
    .ch_mask           (ch_mask),
    .check_ram_busy    (check_ram_busy),
    .check_ram_done    (check_ram_done),
    .check_ram_error   (check_ram_error),
    .check_ram_timeout (check_ram_timeout),
    .init_check_en     (init_check_en),
    .init_check_done   (init_check_done),
    .init_check_error  (init_check_error),
    .ch_done_status    (ch_done_status),
    .ch_err_status     (ch_err_status)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    int            at_cyc;
    logic          err;
    logic          to;
    logic [CH-1:0] dst;
    logic [CH-1:0] est;
  } exp_t;

  exp_t exp_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endfunction

  // Monitor: every done pulse is matched against the oldest expected run
  always @(negedge sys_clk) begin
    exp_t e;
    if (!glbl_rst) begin
      if (check_ram_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.at_cyc);
          check("done_error", {31'd0, check_ram_error}, {31'd0, e.err});
          check("done_timeout", {31'd0, check_ram_timeout}, {31'd0, e.to});
          check("done_status", {16'd0, ch_done_status}, {16'd0, e.dst});
          check("err_status", {16'd0, ch_err_status}, {16'd0, e.est});
        end
      end else if (check_ram_error || check_ram_timeout) begin
        check("flag_without_done", 32'd1, 32'd0);
      end
    end
  end

  // Reference model: walk WAIT cycles applying error > complete > timeout
  task automatic model(input logic [CH-1:0] m, input int dt[CH], input int et[CH],
                       output int x, output exp_t e);
    logic errp, comp;
    e.to = 1'b0;
    x = -1;
    if (m != '0) begin
      for (int c = 1; c <= T; c++) begin
        errp = 1'b0;
        comp = 1'b1;
        for (int i = 0; i < CH; i++) begin
          if (m[i]) begin
            if (et[i] >= 0 && et[i] <= c) errp = 1'b1;
            if (!(dt[i] >= 0 && dt[i] <= c)) comp = 1'b0;
          end
        end
`ifdef CM811_CHECK_RUN_ALL_EN
        errp = 1'b0;
`endif
        if (errp || comp) begin
          x = c;
          break;
        end
        if (c == T) begin
          x = c;
          e.to = 1'b1;
        end
      end
    end
    for (int i = 0; i < CH; i++) begin
      e.dst[i] = m[i] && dt[i] >= 0 && dt[i] <= x;
      e.est[i] = m[i] && et[i] >= 0 && et[i] <= x;
    end
    e.err = |e.est;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge sys_clk);
    while (check_ram_busy && k < 300) begin
      @(negedge sys_clk);
      k++;
    end
    if (k >= 300) check("idle_wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_case(input logic [CH-1:0] m, input int dt[CH], input int et[CH]);
    int   x;
    exp_t e;
    logic [CH-1:0] dv, ev;
    model(m, dt, et, x, e);
    wait_idle();
    check_ram_en = 1'b1;
    ch_mask      = m;
    e.at_cyc     = cyc + x + 2;
    exp_q.push_back(e);
    @(negedge sys_clk);
    check_ram_en = 1'b0;
    ch_mask      = CH'($urandom);
    check("launch_en", {16'd0, init_check_en}, {16'd0, m});
    for (int t = 0; t <= x + 1; t++) begin
      if (t == x + 1) begin
        dv = CH'($urandom);
        ev = CH'($urandom);
      end else begin
        for (int i = 0; i < CH; i++) begin
          dv[i] = m[i] ? (dt[i] == t) : 1'($urandom);
          ev[i] = m[i] ? (et[i] == t) : 1'($urandom);
        end
      end
      init_check_done  = dv;
      init_check_error = ev;
      if (t == 1 || t == 4) check("en_only_in_launch", {16'd0, init_check_en}, 32'd0);
      check_ram_en = (t == 3 && x > 4) ? 1'($urandom) : 1'b0;
      @(negedge sys_clk);
    end
    init_check_done  = '0;
    init_check_error = '0;
    check_ram_en     = 1'b0;
  endtask

  task automatic reset_mid_run();
    wait_idle();
    check_ram_en = 1'b1;
    ch_mask      = 16'hFFFF;
    @(negedge sys_clk);
    check_ram_en    = 1'b0;
    init_check_done = 16'h0011;
    @(negedge sys_clk);
    init_check_done = '0;
    repeat (3) @(negedge sys_clk);
    check_ram_en = 1'b1;
    @(negedge sys_clk);
    check_ram_en = 1'b0;
    check("restart_ignored_busy", {31'd0, check_ram_busy}, 32'd1);
    check("restart_no_relaunch", {16'd0, init_check_en}, 32'd0);
    check("status_before_reset", {16'd0, ch_done_status}, 32'h0011);
    glbl_rst = 1'b1;
    @(negedge sys_clk);
    glbl_rst = 1'b0;
    check("rst_outputs", {check_ram_busy, check_ram_done, check_ram_error, check_ram_timeout},
          32'd0);
    check("rst_status", {ch_done_status, ch_err_status}, 32'd0);
    check("rst_en", {16'd0, init_check_en}, 32'd0);
    repeat (10) @(negedge sys_clk);
    check("rst_stays_idle", {31'd0, check_ram_busy}, 32'd0);
  endtask

  initial begin
    int dt[CH];
    int et[CH];
    logic [CH-1:0] m;
    repeat (3) @(negedge sys_clk);
    check("reset_outputs", {check_ram_busy, check_ram_done, check_ram_error, check_ram_timeout},
          32'd0);
    check("reset_en", {16'd0, init_check_en}, 32'd0);
    check("reset_status", {ch_done_status, ch_err_status}, 32'd0);
    glbl_rst = 1'b0;

    for (int i = 0; i < CH; i++) begin dt[i] = 2 + (i * 38) / 15; et[i] = -1; end
    run_case(16'hFFFF, dt, et);

    for (int i = 0; i < CH; i++) begin dt[i] = -1; et[i] = -1; end
    dt[4] = 3; dt[5] = 20; dt[6] = 5; dt[7] = 30; et[5] = 10; et[2] = 4; et[9] = 6;
    run_case(16'h00F0, dt, et);

    for (int i = 0; i < CH; i++) begin dt[i] = -1; et[i] = -1; end
    dt[0] = 5;
    run_case(16'h0003, dt, et);

    run_case(16'h0000, dt, et);

    reset_mid_run();

    for (int i = 0; i < CH; i++) begin dt[i] = -1; et[i] = -1; end
    dt[3] = 7; et[3] = 7;
    run_case(16'h0008, dt, et);

    for (int r = 0; r < 30; r++) begin
      m = ($urandom_range(0, 7) == 0) ? '0 : CH'($urandom);
      for (int i = 0; i < CH; i++) begin
        dt[i] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 60));
        et[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 60)) : -1;
      end
      run_case(m, dt, et);
    end

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge sys_clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (5) @(negedge sys_clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
